// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchronizer, 3-sample majority vote per bit, valid/ready output holding register.
// Optional parity stage is compiled in with `define UART_RX_OS_PARITY_EN.
module uart_rx_os #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 100,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_rx,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_parity_err,
  output logic             o_frame_err,
  output logic             o_overrun,
  output logic             o_busy
);

  localparam int unsigned PW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(WIDTH + 1);

  localparam logic [PW-1:0] PH_S0   = PW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW-1:0] PH_S1   = PW'(CLKS_PER_BIT / 2);
  localparam logic [PW-1:0] PH_DEC  = PW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  // Elaboration-time parameter sanity checks
  if (WIDTH < 5 || WIDTH > 9) begin : g_bad_width
    $error("uart_rx_os: WIDTH must be 5..9");
  end
  if (CLKS_PER_BIT < 8) begin : g_bad_cpb
    $error("uart_rx_os: CLKS_PER_BIT must be at least 8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_os: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_podd
    $error("uart_rx_os: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_OS_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t state, state_next;

  logic             rx_meta, rx_sync, rx_prev;
  logic [1:0]       flush_cnt;
  logic [PW-1:0]    phase;
  logic             samp0, samp1;
  logic [BW-1:0]    bit_cnt;
  logic             stop_cnt;
  logic [WIDTH-1:0] shreg;

  logic fall_edge, decide, vote, parity_err_c;
  logic phase_clr, bit_clr, shift_en, stop_inc, frame_done, frame_bad;
`ifdef UART_RX_OS_PARITY_EN
  logic par_bit, par_load;
`endif

  // Edge detection waits until the synchronizer holds real line samples after reset
  assign fall_edge = (flush_cnt == 2'd3) && rx_prev && !rx_sync;
  assign decide    = (phase == PH_DEC);
  assign vote      = (samp0 & samp1) | (samp0 & rx_sync) | (samp1 & rx_sync);

`ifdef UART_RX_OS_PARITY_EN
  assign parity_err_c = ((^shreg) ^ par_bit) != 1'(PARITY_ODD);
`else
  assign parity_err_c = 1'b0;
`endif

  // Synchronizer and edge-detect history
  always_ff @(posedge clk) begin
    if (i_reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      flush_cnt <= 2'd0;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (flush_cnt != 2'd3) flush_cnt <= flush_cnt + 2'd1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_next = state;
    phase_clr  = 1'b0;
    bit_clr    = 1'b0;
    shift_en   = 1'b0;
    stop_inc   = 1'b0;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
`ifdef UART_RX_OS_PARITY_EN
    par_load   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (fall_edge) begin
          state_next = START;
          phase_clr  = 1'b1;
        end
      end
      START: begin
        if (decide) begin
          if (vote) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
            bit_clr    = 1'b1;
          end
        end
      end
      DATA: begin
        if (decide) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_OS_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_OS_PARITY_EN
      PARITY: begin
        if (decide) begin
          par_load   = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (decide) begin
          if (!vote) begin
            frame_bad  = 1'b1;
            phase_clr  = 1'b1;
            state_next = WAIT_HIGH;
          end else if (stop_cnt == STOP_LAST) begin
            frame_done = 1'b1;
            state_next = IDLE;
          end else begin
            stop_inc = 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_sync && phase == PH_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit timing, sampling and shift register
  always_ff @(posedge clk) begin
    if (i_reset) begin
      phase    <= '0;
      samp0    <= 1'b1;
      samp1    <= 1'b1;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
`ifdef UART_RX_OS_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      if (phase_clr || state == IDLE) begin
        phase <= '0;
      end else if (state == WAIT_HIGH) begin
        // In WAIT_HIGH the phase counter measures a continuous high run
        if (!rx_sync || phase == PH_LAST) phase <= '0;
        else                              phase <= phase + PW'(1);
      end else begin
        phase <= (phase == PH_LAST) ? '0 : phase + PW'(1);
      end

      if (phase == PH_S0) samp0 <= rx_sync;
      if (phase == PH_S1) samp1 <= rx_sync;

      if (bit_clr) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
      end else begin
        if (shift_en) bit_cnt <= bit_cnt + BW'(1);
        if (stop_inc) stop_cnt <= 1'b1;
      end

      if (shift_en) shreg <= {vote, shreg[WIDTH-1:1]};
`ifdef UART_RX_OS_PARITY_EN
      if (par_load) par_bit <= vote;
`endif
    end
  end

  // Output holding register with valid/ready handshake
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_frame_err <= frame_bad;
      o_overrun   <= 1'b0;
      o_busy      <= (state_next != IDLE);
      if (frame_done) begin
        if (!o_valid || i_ready) begin
          o_data       <= shreg;
          o_parity_err <= parity_err_c;
          o_valid      <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: randomized frames against a queue-based model of the serial protocol.
module tb_uart_rx_os;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned CPB       = 16;
  localparam int unsigned STOP_BITS = 1;
  localparam int unsigned PODD      = 0;
`ifdef UART_RX_OS_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             i_reset, i_rx, i_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_valid, o_parity_err, o_frame_err, o_overrun, o_busy;

  uart_rx_os #(
    .WIDTH(WIDTH), .CLKS_PER_BIT(CPB), .STOP_BITS(STOP_BITS), .PARITY_ODD(PODD)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_rx(i_rx),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_parity_err(o_parity_err), .o_frame_err(o_frame_err),
    .o_overrun(o_overrun), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] got_q[$];
  logic             perr_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int ferr_cnt = 0, ovr_cnt = 0, valid_cycles = 0;

  // Observe the consumer side of the handshake
  always @(negedge clk) begin
    if (!i_reset) begin
      if (o_valid) valid_cycles++;
      if (o_valid && i_ready) begin
        got_q.push_back(o_data);
        perr_q.push_back(o_parity_err);
      end
      if (o_frame_err) ferr_cnt++;
      if (o_overrun)   ovr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    i_rx = b;
    tick(CPB);
  endtask

  // Serialize one frame: start, WIDTH data bits LSB first, optional parity, stop bits
  task automatic send_frame(input logic [WIDTH-1:0] data, input logic stop_val, input logic par_flip);
    logic pbit;
    pbit = (^data) ^ 1'(PODD) ^ par_flip;
    drive_bit(1'b0);
    check("busy_in_frame", 32'(o_busy), 32'd1);
    for (int i = 0; i < int'(WIDTH); i++) drive_bit(data[i]);
    if (PAR_EN) drive_bit(pbit);
    for (int s = 0; s < int'(STOP_BITS); s++) drive_bit((s == 0) ? stop_val : 1'b1);
    i_rx = 1'b1;
  endtask

  int base;
  logic [WIDTH-1:0] d;

  initial begin
    i_reset = 1'b1;
    i_rx    = 1'b1;
    i_ready = 1'b0;
    tick(3);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data",  32'(o_data),  32'd0);
    check("rst_busy",  32'(o_busy),  32'd0);
    check("rst_ferr",  32'(o_frame_err), 32'd0);
    check("rst_ovr",   32'(o_overrun),   32'd0);
    check("rst_perr",  32'(o_parity_err), 32'd0);
    i_reset = 1'b0;
    tick(4);

    // Single frame 0xA5 with consumer always ready
    i_ready = 1'b1;
    valid_cycles = 0;
    base = got_q.size();
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(CPB);
    check("a5_count", 32'(got_q.size() - base), 32'd1);
    if (got_q.size() > base) check("a5_data", 32'(got_q[base]), 32'hA5);
    check("a5_valid_width", 32'(valid_cycles), 32'd1);
    check("a5_ferr", 32'(ferr_cnt), 32'd0);
    check("a5_ovr",  32'(ovr_cnt),  32'd0);
    check("a5_perr", 32'(o_parity_err), 32'd0);

    // Random back-to-back and gapped frames
    base = got_q.size();
    exp_q.delete();
    for (int n = 0; n < 16; n++) begin
      d = WIDTH'($urandom);
      exp_q.push_back(d);
      send_frame(d, 1'b1, 1'b0);
      tick($urandom_range(0, CPB / 2));
    end
    tick(CPB);
    check("rnd_count", 32'(got_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      check($sformatf("rnd_data%0d", i), 32'(got_q[base + i]), 32'(exp_q[i]));
      check($sformatf("rnd_perr%0d", i), 32'(perr_q[base + i]), 32'd0);
    end
    check("rnd_ferr", 32'(ferr_cnt), 32'd0);

    // Short low glitch must be rejected silently
    base = got_q.size();
    i_rx = 1'b0;
    tick(4);
    i_rx = 1'b1;
    tick(2 * CPB);
    check("glitch_count", 32'(got_q.size() - base), 32'd0);
    check("glitch_ferr",  32'(ferr_cnt), 32'd0);
    check("glitch_busy",  32'(o_busy),   32'd0);

    // Framing error followed by a held-low break
    base = got_q.size();
    send_frame(8'h3C, 1'b0, 1'b0);
    i_rx = 1'b0;
    tick(2 * CPB);
    check("ferr_count",     32'(ferr_cnt), 32'd1);
    check("ferr_no_data",   32'(got_q.size() - base), 32'd0);
    check("ferr_busy_low",  32'(o_busy), 32'd1);
    i_rx = 1'b1;
    tick(CPB - 2);
    check("ferr_busy_wait", 32'(o_busy), 32'd1);
    tick(8);
    check("ferr_busy_idle", 32'(o_busy), 32'd0);
    check("ferr_count_end", 32'(ferr_cnt), 32'd1);

    // Overrun: consumer stalled across two frames
    i_ready = 1'b0;
    ovr_cnt = 0;
    base = got_q.size();
    send_frame(8'h11, 1'b1, 1'b0);
    tick(2);
    check("ovr_valid1", 32'(o_valid), 32'd1);
    check("ovr_data1",  32'(o_data),  32'h11);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(CPB);
    check("ovr_pulse",  32'(ovr_cnt), 32'd1);
    check("ovr_data2",  32'(o_data),  32'h11);
    check("ovr_valid2", 32'(o_valid), 32'd1);
    i_ready = 1'b1;
    tick(1);
    check("ovr_accept_count", 32'(got_q.size() - base), 32'd1);
    if (got_q.size() > base) check("ovr_accept_data", 32'(got_q[base]), 32'h11);
    check("ovr_valid_clr", 32'(o_valid), 32'd0);

`ifdef UART_RX_OS_PARITY_EN
    // Wrong parity bit: word still delivered with the error flag
    base = got_q.size();
    send_frame(8'h07, 1'b1, 1'b1);
    tick(CPB);
    check("par_count", 32'(got_q.size() - base), 32'd1);
    if (got_q.size() > base) begin
      check("par_data", 32'(got_q[base]), 32'h07);
      check("par_err",  32'(perr_q[base]), 32'd1);
    end
`endif

    // Reset in the middle of data bit 4 with a word pending
    i_ready = 1'b0;
    send_frame(8'h77, 1'b1, 1'b0);
    tick(2);
    check("rst_mid_pending", 32'(o_valid), 32'd1);
    d = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    i_rx = d[4];
    tick(CPB / 2);
    i_reset = 1'b1;
    tick(1);
    check("rst_mid_valid", 32'(o_valid), 32'd0);
    check("rst_mid_data",  32'(o_data),  32'd0);
    check("rst_mid_busy",  32'(o_busy),  32'd0);
    check("rst_mid_ferr",  32'(o_frame_err), 32'd0);
    check("rst_mid_ovr",   32'(o_overrun),   32'd0);
    i_rx = 1'b1;
    tick(3);
    i_reset = 1'b0;
    tick(CPB);
    i_ready = 1'b1;
    ferr_cnt = 0;
    base = got_q.size();
    send_frame(8'h5A, 1'b1, 1'b0);
    tick(CPB);
    check("post_rst_count", 32'(got_q.size() - base), 32'd1);
    if (got_q.size() > base) check("post_rst_data", 32'(got_q[base]), 32'h5A);
    check("post_rst_ferr", 32'(ferr_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter WIDTH, default 8, data bits per frame, legal range 5..9, LSB first.
REQ-002 Parameter CLKS_PER_BIT, default 100, clk cycles per bit period, minimum 8.
REQ-003 Parameter STOP_BITS, default 1, number of stop bits checked, legal values 1 or 2.
REQ-004 Parameter PARITY_ODD, default 0, selects odd parity when 1 and even parity when 0; it takes effect only when UART_RX_OS_PARITY_EN is defined.
REQ-005 Port clk, input, 1, rising-edge clock.
REQ-006 Port i_reset, input, 1, reset: synchronous, active-high.
REQ-007 Port i_rx, input, 1, asynchronous serial line that idles high.
REQ-008 Port o_data, output, WIDTH, received word, valid while o_valid is high.
REQ-009 Port o_valid, output, 1, data-available flag in a valid/ready handshake.
REQ-010 Port i_ready, input, 1, consumer accepts o_data when o_valid and i_ready are both high.
REQ-011 Port o_parity_err, output, 1, sideband flag qualified by o_valid; it is constant 0 when parity is compiled out.
REQ-012 Port o_frame_err, output, 1, one-cycle pulse when a stop bit is sampled low.
REQ-013 Port o_overrun, output, 1, one-cycle pulse when a completed frame is dropped because the holding register is full.
REQ-014 Port o_busy, output, 1, high in every state except IDLE.

Function
REQ-015 i_rx SHALL pass through a 2-flop synchronizer that resets to 1; all references to "line" below mean the synchronized signal.
REQ-016 The FSM SHALL use states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-017 In IDLE, a falling edge on the line SHALL move the FSM to START and zero the bit-phase counter, so the bit timing is re-aligned to every frame.
REQ-018 Each bit value SHALL be the 2-of-3 majority of samples taken at phase counts CLKS_PER_BIT/2-1, CLKS_PER_BIT/2 and CLKS_PER_BIT/2+1.
REQ-019 The bit decision SHALL be made at phase CLKS_PER_BIT/2+1; the phase counter SHALL wrap from CLKS_PER_BIT-1 to 0.
REQ-020 If the majority vote in START is 1, the FSM SHALL treat it as a glitch and return to IDLE with no output and no error.
REQ-021 DATA SHALL collect exactly WIDTH bits, LSB first, using a bit counter of width $clog2(WIDTH+1).
REQ-022 After DATA, the FSM SHALL go to PARITY if parity is enabled, otherwise directly to STOP.
REQ-023 STOP SHALL check STOP_BITS stop bits; any stop bit sampled 0 SHALL pulse o_frame_err, discard the frame and move the FSM to WAIT_HIGH.
REQ-024 WAIT_HIGH SHALL stay there until the line has been 1 for one full bit period, then move to IDLE; this covers break conditions.
REQ-025 A good frame SHALL load o_data and o_parity_err and set o_valid on the cycle after the decision of the final stop bit.
REQ-026 The FSM SHALL then go directly to IDLE, so a start edge arriving half a bit after that decision is caught.
REQ-027 o_valid SHALL clear on the cycle after a cycle in which o_valid and i_ready are both high.
REQ-028 If o_valid is high and i_ready is low when a new frame completes, the old data SHALL be retained and o_overrun SHALL pulse.
REQ-029 If a new frame completes in the same cycle that the old word is accepted, the new word SHALL load, o_valid SHALL remain high and no overrun SHALL be flagged.
REQ-030 o_data SHALL hold its value while o_valid is low; consumers SHALL NOT rely on its contents in that case.

Reset
REQ-031 Reset SHALL be synchronous, active-high on i_reset, sampled on the rising edge of clk.
REQ-032 Reset SHALL force: state IDLE, all counters 0, synchronizer flops 1, o_data 0, o_valid 0, o_parity_err 0, o_frame_err 0, o_overrun 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no output; reception SHALL restart only on a fresh falling edge after reset is released.

Configuration
REQ-034 Macro UART_RX_OS_PARITY_EN defined SHALL compile in the PARITY state.
REQ-035 With UART_RX_OS_PARITY_EN, o_parity_err SHALL be set when the XOR of the data bits and the parity bit does not equal PARITY_ODD; the word is still delivered.
REQ-036 With UART_RX_OS_PARITY_EN undefined, the PARITY state and its logic SHALL be absent and o_parity_err SHALL be tied to 0.

Verification
REQ-037 WIDTH=8, CLKS_PER_BIT=16, send 0xA5 with 1 stop bit and i_ready=1 -> o_valid pulses one cycle with o_data=0xA5; no error flags.
REQ-038 Line low for 4 cycles, then high -> START aborts to IDLE; no o_valid and no o_frame_err.
REQ-039 Send 0x3C with the stop bit forced 0 -> o_frame_err pulses once, no o_valid; FSM holds in WAIT_HIGH until the line is high for 16 cycles.
REQ-040 Hold i_ready=0, send 0x11 then 0x22 -> o_data stays 0x11 and o_overrun pulses once after the second frame.
REQ-041 With UART_RX_OS_PARITY_EN, PARITY_ODD=0, send 0x07 with parity bit 0 -> o_valid is high with o_parity_err=1 and o_data=0x07.
REQ-042 Assert i_reset during data bit 4 of a frame -> all outputs are 0 next cycle and the following clean frame 0x5A is received correctly.
